// File: rtl/wb_mem_responder.sv
// Wishbone B4 classic-cycle responder over a small word-addressed register memory,
// with a fixed number of wait states, byte-lane writes and an error response for unmapped words.
module wb_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [2:0]              cnt_r;
  logic [2:0]              cnt_nxt_s;
  logic                    access_s;
  logic                    use_live_s;
  logic                    we_r;
  logic [ADDR_WIDTH-1:0]   adr_r;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [SEL_WIDTH-1:0]    sel_r;
  logic                    acc_we_s;
  logic [ADDR_WIDTH-1:0]   acc_adr_s;
  logic [DATA_WIDTH-1:0]   acc_dat_s;
  logic [SEL_WIDTH-1:0]    acc_sel_s;
  logic                    in_range_s;
  logic                    ack_r;
  logic                    err_r;
  logic [DATA_WIDTH-1:0]   rdat_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [SEL_WIDTH-1:0]  lanes
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      if (lanes[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Next-state logic; access_s marks the edge that enters RESP and performs the access.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    access_s    = 1'b0;
    use_live_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          if (WAIT_STATES == 0) begin
            state_nxt_s = ST_RESP;
            access_s    = 1'b1;
            use_live_s  = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WS_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 3'd0) begin
          state_nxt_s = ST_RESP;
          access_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // With zero wait states the access happens on the sampling edge, so the live bus is used.
  always_comb begin
    if (use_live_s) begin
      acc_we_s  = we_i;
      acc_adr_s = adr_i;
      acc_dat_s = dat_i;
      acc_sel_s = sel_i;
    end else begin
      acc_we_s  = we_r;
      acc_adr_s = adr_r;
      acc_dat_s = dat_r;
      acc_sel_s = sel_r;
    end
    in_range_s = ({1'b0, acc_adr_s} < DEPTH_LIMIT);
  end

  // State, request latch, registered response and memory array.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      we_r    <= 1'b0;
      adr_r   <= '0;
      dat_r   <= '0;
      sel_r   <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdat_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (state_r == ST_IDLE && cyc_i && stb_i) begin
        we_r  <= we_i;
        adr_r <= adr_i;
        dat_r <= dat_i;
        sel_r <= sel_i;
      end
      ack_r  <= access_s && in_range_s;
      err_r  <= access_s && !in_range_s;
      rdat_r <= (access_s && in_range_s && !acc_we_s) ? mem_r[acc_adr_s] : '0;
      if (access_s && in_range_s && acc_we_s) begin
        mem_r[acc_adr_s] <= merge_lanes(mem_r[acc_adr_s], acc_dat_s, acc_sel_s);
      end
    end
  end

  assign dat_o = rdat_r;
  assign ack_o = ack_r;
  assign err_o = err_r;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances (1, 3 and 0 wait states), directed vector
// table, hand-written reset/abort/back-to-back sequences and randomized traffic vs a memory model.
module tb_wb_mem_responder;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;

  int ws_of [3] = '{1, 3, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst  [3];
  logic          cyc  [3];
  logic          stb  [3];
  logic          we   [3];
  logic [AW-1:0] adr  [3];
  logic [DW-1:0] wdat [3];
  logic [3:0]    sel  [3];
  logic [DW-1:0] rdat [3];
  logic          ack  [3];
  logic          err  [3];

  logic [DW-1:0] mem_m [3][16];
  int vectors = 0;
  int fails   = 0;

  typedef struct {
    bit          wr;
    int          a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          ok;
    logic [31:0] rd;
  } vec_t;

  wb_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .adr_i(adr[0]),
    .dat_i(wdat[0]), .sel_i(sel[0]), .dat_o(rdat[0]), .ack_o(ack[0]), .err_o(err[0]));
  wb_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .adr_i(adr[1]),
    .dat_i(wdat[1]), .sel_i(sel[1]), .dat_o(rdat[1]), .ack_o(ack[1]), .err_o(err[1]));
  wb_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst[2]), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]), .adr_i(adr[2]),
    .dat_i(wdat[2]), .sel_i(sel[2]), .dat_o(rdat[2]), .ack_o(ack[2]), .err_o(err[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic model_clear(input int d);
    for (int i = 0; i < 16; i++) mem_m[d][i] = 32'h0;
  endtask

  // Memory behaviour: a word outside DEPTH errors; a write replaces only the selected bytes.
  task automatic model_apply(input int d, input bit wr, input int a, input logic [31:0] data,
                             input logic [3:0] s, output bit ok, output logic [31:0] rd);
    logic [31:0] mask;
    ok = (a < DEPTH);
    rd = 32'h0;
    if (ok) begin
      if (wr) begin
        mask = 32'h0;
        for (int k = 0; k < 4; k++) if (s[k]) mask = mask | (32'hFF << (8 * k));
        mem_m[d][a] = (mem_m[d][a] & ~mask) | (data & mask);
      end else begin
        rd = mem_m[d][a];
      end
    end
  endtask

  // One classic-cycle transfer: strobe held until termination, then released.
  task automatic xfer(input int d, input bit wr, input int a, input logic [31:0] data,
                      input logic [3:0] s, input bit exp_ok, input logic [31:0] exp_rd,
                      input string name);
    int lat;
    logic got_ack, got_err;
    logic [31:0] got_dat;
    lat = -1; got_ack = 1'b0; got_err = 1'b0; got_dat = 32'h0;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = wr; adr[d] = AW'(a); wdat[d] = data; sel[d] = s;
    for (int j = 0; j < 12 && lat < 0; j++) begin
      @(posedge clk); #1;
      if (ack[d] || err[d]) begin
        lat = j; got_ack = ack[d]; got_err = err[d]; got_dat = rdat[d];
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    check($sformatf("%s latency", name), lat, ws_of[d]);
    check($sformatf("%s ack/err", name), {30'h0, got_ack, got_err}, exp_ok ? 32'h2 : 32'h1);
    check($sformatf("%s dat", name), got_dat, (exp_ok && !wr) ? exp_rd : 32'h0);
    @(posedge clk); #1;
    check($sformatf("%s release", name), {ack[d], err[d], 30'h0} | (rdat[d] != 32'h0 ? 32'h1 : 32'h0), 32'h0);
  endtask

  task automatic model_xfer(input int d, input bit wr, input int a, input logic [31:0] data,
                            input logic [3:0] s, input string name);
    bit ok;
    logic [31:0] rd;
    model_apply(d, wr, a, data, s, ok, rd);
    xfer(d, wr, a, data, s, ok, rd, name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    int idx;
    bit ok;
    logic [31:0] rd;

    tbl[0]  = '{1'b1, 5,  32'h12345678, 4'hF, 1'b1, 32'h0};
    tbl[1]  = '{1'b0, 5,  32'h0,        4'hF, 1'b1, 32'h12345678};
    tbl[2]  = '{1'b1, 2,  32'hAABBCCDD, 4'hF, 1'b1, 32'h0};
    tbl[3]  = '{1'b1, 2,  32'h11223344, 4'h5, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 2,  32'h0,        4'hF, 1'b1, 32'hAA22CC44};
    tbl[5]  = '{1'b1, 11, 32'h5A5A0001, 4'hF, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 12, 32'h0,        4'hF, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 15, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 11, 32'h0,        4'hF, 1'b1, 32'h5A5A0001};
    tbl[9]  = '{1'b1, 2,  32'h99999999, 4'h0, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 2,  32'h0,        4'hF, 1'b1, 32'hAA22CC44};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; wdat[d] = '0; sel[d] = '0;
      model_clear(d);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset state dut%0d", d), {ack[d], err[d], 30'h0} | rdat[d], 32'h0);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;

    // Directed table on the one-wait-state instance.
    for (int i = 0; i < 11; i++) begin
      model_apply(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, ok, rd);
      xfer(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].ok, tbl[i].rd, $sformatf("table%0d", i));
    end

    // Reset in the middle of a write's wait state.
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 4'd3; wdat[0] = 32'hDEADBEEF; sel[0] = 4'hF;
    @(posedge clk); #1;
    check("reset-abort wait", {30'h0, ack[0], err[0]}, 32'h0);
    rst[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("reset-abort in reset", {30'h0, ack[0], err[0]}, 32'h0);
    end
    cyc[0] = 1'b0; stb[0] = 1'b0; rst[0] = 1'b1;
    model_clear(0);
    xfer(0, 1'b0, 3, 32'h0, 4'hF, 1'b1, 32'h0, "post-reset read3");
    xfer(0, 1'b0, 5, 32'h0, 4'hF, 1'b1, 32'h0, "post-reset read5");

    // Abort after one wait cycle on the three-wait-state instance.
    model_xfer(1, 1'b1, 1, 32'h01020304, 4'hF, "abort preload");
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 4'd1; wdat[1] = 32'hCAFEF00D; sel[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort before drop", {30'h0, ack[1], err[1]}, 32'h0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("abort no termination", {30'h0, ack[1], err[1]}, 32'h0);
    end
    model_xfer(1, 1'b0, 1, 32'h0, 4'hF, "abort readback");

    // Back-to-back reads with strobe held high on the zero-wait-state instance.
    model_xfer(2, 1'b1, 0, 32'hA0A0A0A0, 4'hF, "b2b preload0");
    model_xfer(2, 1'b1, 1, 32'hA1A1A1A1, 4'hF, "b2b preload1");
    model_xfer(2, 1'b1, 2, 32'hA2A2A2A2, 4'hF, "b2b preload2");
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 4'd0; sel[2] = 4'hF;
    check("b2b ack before", {31'h0, ack[2]}, 32'h0);
    idx = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      check($sformatf("b2b ack cycle%0d", e), {31'h0, ack[2]}, (e % 2 == 0) ? 32'h1 : 32'h0);
      if (ack[2]) begin
        check($sformatf("b2b dat%0d", idx), rdat[2], mem_m[2][idx]);
        idx++;
        adr[2] = AW'(idx);
      end
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    check("b2b read count", idx, 3);

    // Randomized traffic against the memory model.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        model_xfer(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
                   4'($urandom_range(0, 15)), $sformatf("rand dut%0d #%0d", d, n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
